// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the MULTU/DIVU sequencer.
//   ALU select codes, FSM state encoding and op codes.
//   Used by alu_seq_ctrl and alu_seq_shreg.
package alu_seq_pkg;

    // Shared ALU select codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Op select on the op input
    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/alu_seq_shreg.sv
// alu_seq_shreg: 2*WIDTH HI/LO shift register for the MULTU/DIVU sequencer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              hi <= load_hi, lo <= load_lo
//   shr               {hi,lo} <= {ins, hi_in, lo} >> 1   (multiply step)
//   shl               hi <= hi_in, lo <= {lo << 1, ins}  (divide step)
//   load_hi, load_lo  load values
//   hi_in, ins        replacement upper half and inserted bit for shifts
//   hi, lo            register contents
// Priority: rst > load > shr > shl.
module alu_seq_shreg
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shr,
    input  logic             shl,
    input  logic [WIDTH-1:0] load_hi,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] hi_in,
    input  logic             ins,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // HI/LO register with load / shift controls
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (load) begin
            hi <= load_hi;
            lo <= load_lo;
        end else if (shr) begin
            hi <= {ins, hi_in[WIDTH-1:1]};
            lo <= {hi_in[0], lo[WIDTH-1:1]};
        end else if (shl) begin
            hi <= hi_in;
            lo <= {lo[WIDTH-2:0], ins};
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multicycle MULTU/DIVU sequencer driving the shared EX-stage ALU.
//   One shift-add (MULTU) or restoring-subtract (DIVU) iteration per cycle,
//   results accumulate in HI/LO.
// Build option: define ALU_SEQ_DIV_EN to support DIVU; otherwise op=1 starts
//   are ignored, div_zero is tied 0 and the divide datapath is left out.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         issue pulse, 0 = MULTU / 1 = DIVU
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   rd_hilo           ID-stage instruction reads HI/LO
//   alu_ctrl, alu_a, alu_b  shared ALU select and operands
//   alu_y             ALU result, bit WIDTH = carry-out
//   busy, done, stall sequence status, one-cycle done, hazard stall
//   div_zero          last DIVU had divisor 0
//   hi, lo            HI/LO registers
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_hilo,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH:0]   alu_y,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;      // M for MULTU, D for DIVU
    logic             is_div;
    logic             accept;
    logic             dz;
    logic             shr, shl, ins;
    logic [WIDTH-1:0] hi_in, load_hi, load_lo;

`ifdef ALU_SEQ_DIV_EN
    logic quot;

    assign accept  = start & (state != CALC);
    assign dz      = (op == OP_DIVU) & (src_b == '0);
    assign load_hi = dz ? src_a : '0;
    assign load_lo = dz ? '1 : ((op == OP_DIVU) ? src_a : src_b);
    // msb shifted out of hi means the partial remainder already exceeds D
    assign quot    = hi[WIDTH-1] | alu_y[WIDTH];

    // Op and divide-by-zero flag captured on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            is_div   <= op;
            div_zero <= dz;
        end
    end
`else
    assign accept   = start & (state != CALC) & (op == OP_MULTU);
    assign dz       = 1'b0;
    assign load_hi  = '0;
    assign load_lo  = src_b;
    assign is_div   = 1'b0;
    assign div_zero = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = dz ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter and latched operand
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            opnd <= '0;
        end else if (accept) begin
            cnt  <= CNT_W'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
            opnd <= (op == OP_DIVU) ? src_b : src_a;
`else
            opnd <= src_a;
`endif
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Outputs: ALU drive and status decoded from state
    always_comb begin
        alu_ctrl = ALU_AND;
        alu_a    = '0;
        alu_b    = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            CALC: begin
                busy     = 1'b1;
                alu_b    = opnd;
                alu_ctrl = ALU_ADD;
                alu_a    = hi;
`ifdef ALU_SEQ_DIV_EN
                if (is_div) begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = {hi[WIDTH-2:0], lo[WIDTH-1]};
                end
`endif
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign stall = busy & rd_hilo;

    // Shift-register step selection for the current iteration
    always_comb begin
        shr   = 1'b0;
        shl   = 1'b0;
        ins   = 1'b0;
        hi_in = hi;
        if (state == CALC) begin
            if (!is_div) begin
                shr = 1'b1;
                if (lo[0]) begin
                    hi_in = alu_y[WIDTH-1:0];
                    ins   = alu_y[WIDTH];
                end
            end
`ifdef ALU_SEQ_DIV_EN
            else begin
                shl   = 1'b1;
                ins   = quot;
                hi_in = quot ? alu_y[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
            end
`endif
        end
    end

    alu_seq_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shr     (shr),
        .shl     (shl),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .hi_in   (hi_in),
        .ins     (ins),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl with a behavioural
// shared ALU and a reference model based on native * / % arithmetic.
module tb_alu_seq_ctrl;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          rd_hilo;
    logic [2:0]    alu_ctrl;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W:0]    alu_y;
    logic          busy;
    logic          done;
    logic          stall;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            errors;
    int            checks;
    logic [W-1:0]  last_hi;
    logic [W-1:0]  last_lo;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .rd_hilo  (rd_hilo),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU seen by the sequencer
    always_comb begin
        case (alu_ctrl)
            3'b010:  alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            3'b110:  alu_y = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            default: alu_y = {1'b0, alu_a & alu_b};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op at the current negedge and follow it to done.
    // poke > 0 re-asserts start with random operands in that CALC cycle.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke);
        logic [W-1:0] eh, el;
        logic [63:0]  p;
        logic         edz, flow_ok, ctrl_ok;
        logic [2:0]   ectrl;
        int           lat, n;
        edz = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        if (o && b == '0) begin
            eh = a; el = '1; edz = 1'b1;
        end else if (o) begin
            eh = a % b; el = a / b;
        end else
`endif
        begin
            p  = {32'b0, a} * {32'b0, b};
            eh = p[63:32];
            el = p[31:0];
        end
        lat   = edz ? 1 : W + 1;
        ectrl = o ? 3'b110 : 3'b010;

        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start   = 1'b0;
        flow_ok = 1'b1;
        ctrl_ok = 1'b1;
        n = 1;
        while (n <= 100) begin
            rd_hilo = 1'($urandom);
            #1;
            if (busy !== (n < lat) || stall !== ((n < lat) && rd_hilo) || done !== (n == lat))
                flow_ok = 1'b0;
            if (n < lat && alu_ctrl !== ectrl) ctrl_ok = 1'b0;
            if (n == 1 && n < lat && alu_b !== (o ? b : a)) ctrl_ok = 1'b0;
            if (done) break;
            start = (n == poke);
            if (n == poke) begin
                op = 1'($urandom); src_a = $urandom; src_b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start   = 1'b0;
        rd_hilo = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("flow", {63'b0, flow_ok}, 64'd1);
        check("alu_ctrl", {63'b0, ctrl_ok}, 64'd1);
        check("hi", {32'b0, hi}, {32'b0, eh});
        check("lo", {32'b0, lo}, {32'b0, el});
        check("div_zero", {63'b0, div_zero}, {63'b0, edz});
        last_hi = eh;
        last_lo = el;
    endtask

    // Idle cycles after a result: no activity, HI/LO held
    task automatic idle_gap(input int g);
        repeat (g) begin
            @(negedge clk);
            #1;
            check("idle", {62'b0, done, busy}, 64'd0);
            check("hold", {hi, lo}, {last_hi, last_lo});
        end
    endtask

    initial begin
        logic         o;
        logic [W-1:0] a, b;
        errors = 0; checks = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; rd_hilo = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {60'b0, busy, done, stall, div_zero}, 64'd0);
        check("rst_alu", {29'b0, alu_ctrl, alu_a}, 64'd0);
        check("rst_alu_b", {32'b0, alu_b}, 64'd0);
        rst = 1'b0; rd_hilo = 1'b0;
        @(negedge clk);
        #1;

        // Directed multiplies
        do_op(1'b0, 32'd7, 32'd6, 0);
        check("mul7x6", {hi, lo}, 64'd42);
        idle_gap(1);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

`ifdef ALU_SEQ_DIV_EN
        // Directed divides, issued back-to-back from the DONE cycle
        do_op(1'b1, 32'd100, 32'd7, 0);
        check("div100_7", {hi, lo}, {32'd2, 32'd14});
        do_op(1'b1, 32'h8000_0000, 32'd3, 0);
        check("div_msb", {hi, lo}, {32'd2, 32'h2AAA_AAAA});
        do_op(1'b1, 32'd5, 32'd0, 0);
        check("div_zero_res", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        idle_gap(2);
`else
        // DIVU start is ignored in a multiply-only build
        start = 1'b1; op = 1'b1; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("divu_ignored", {61'b0, busy, done, div_zero}, 64'd0);
        check("divu_hold", {hi, lo}, {last_hi, last_lo});
        idle_gap(1);
`endif

        // start during CALC is ignored
        do_op(1'b0, $urandom, $urandom, 5);
        idle_gap(1);

        // Reset in cycle 10 of a multiply aborts it
        start = 1'b1; op = 1'b0; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; rd_hilo = 1'b1;
        @(negedge clk);
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", {60'b0, busy, done, stall, div_zero}, 64'd0);
        check("abort_alu", {32'b0, alu_ctrl, 29'b0}, 64'd0);
        rst = 1'b0; rd_hilo = 1'b0;
        do_op(1'b0, 32'd3, 32'd4, 0);
        check("mul3x4", {hi, lo}, 64'd12);

        // Randomized ops with random gaps (gap 0 = back-to-back)
        repeat (12) begin
`ifdef ALU_SEQ_DIV_EN
            o = 1'($urandom);
`else
            o = 1'b0;
`endif
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            do_op(o, a, b, 0);
            idle_gap($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multicycle MULTU/DIVU sequencer for the pipelined CPU's EX stage. It sequences the shared ALU by driving the ALU select code and operands for one iteration per cycle: shift-add for multiply, restoring subtraction for divide. Results accumulate in the HI/LO registers. It raises a stall to the hazard unit while a result is pending and an instruction reads HI/LO.

## Interface
- WIDTH, 32, operand/HI/LO width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  EX-stage MULTU/DIVU issue pulse
- op  input  1  0 = MULTU, 1 = DIVU
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- rd_hilo  input  1  ID-stage instruction reads HI or LO (MFHI/MFLO)
- alu_ctrl  output  3  select code to shared ALU: AND 3'b000, ADD 3'b010, SUB 3'b110
- alu_a, alu_b  output  WIDTH  ALU operands
- alu_y  input  WIDTH+1  ALU result; bit WIDTH = carry-out (for SUB, 1 = no borrow)
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse: hi/lo final
- stall  output  1  busy & rd_hilo
- div_zero  output  1  last DIVU had divisor 0; held until next accepted start
- hi, lo  output  WIDTH  HI/LO registers

## Operation
- FSM states: IDLE, CALC, DONE.
- In IDLE or DONE, start=1 is accepted:
  - MULTU: hi←0, lo←src_b, latch src_a as M.
  - DIVU: hi←0, lo←src_a, latch src_b as D.
  - Counter←WIDTH−1; go to CALC.
- start in CALC is ignored; no queueing.
- MULTU iteration:
  - alu_ctrl=ADD, alu_a=hi, alu_b=M.
  - If lo[0]=1: {hi,lo}←{alu_y, lo} >> 1, carry-in at the MSB.
  - Else: {hi,lo}←{1'b0, hi, lo} >> 1.
- DIVU iteration:
  - s = {hi, lo} << 1; msb = hi[WIDTH−1].
  - alu_ctrl=SUB, alu_a=s[2·WIDTH−1:WIDTH], alu_b=D.
  - q = msb | alu_y[WIDTH].
  - If q=1, hi←alu_y[WIDTH−1:0]; else hi←s upper half.
  - lo←{s[WIDTH−1:1], q}.
  - Final result: lo = quotient, hi = remainder.
- Divide by zero (DIVU with src_b=0):
  - Skip CALC and go IDLE→DONE directly.
  - hi=src_a, lo={WIDTH{1'b1}}, div_zero=1.
- CALC with counter=0 → DONE. DONE → IDLE unless start is accepted.
- Outside CALC: alu_ctrl=AND, alu_a=alu_b=0.
- Arithmetic is unsigned, modulo 2^WIDTH per half. The counter is $clog2(WIDTH) bits wide.

## Timing
- Start sampled at edge 0 → CALC for cycles 1..WIDTH → done=1 in cycle WIDTH+1. hi/lo are valid from that cycle and held until the next accepted start.
- Divide by zero: done=1 in cycle 1.
- busy=1 in CALC only.
- hi/lo hold intermediate values while busy. Stall guards the reads.
- Back-to-back: start in the DONE cycle re-enters CALC at the next edge. done stays a single pulse.
- Reset values: state=IDLE; hi=lo=0; busy=done=stall=div_zero=0; alu_ctrl=3'b000; alu_a=alu_b=0.
- rst mid-CALC aborts: all outputs take reset values at the next edge, and a start in the following cycle is accepted normally.
- rst has priority over start.

## Configuration
- ALU_SEQ_DIV_EN defined: DIVU supported as above.
- Undefined:
  - start with op=1 is ignored: state, hi and lo are unchanged, and busy and done stay 0.
  - div_zero is tied 0.
  - Divide datapath logic is omitted.

## Structure
- Package alu_seq_pkg holds:
  - ALU select constants ALU_AND/OR/ADD/SUB/SLT (3'b000/001/010/110/111).
  - State encoding (IDLE/CALC/DONE).
  - Op constants OP_MULTU/OP_DIVU.
- One sub-module, alu_seq_shreg: the 2·WIDTH HI/LO shift register with load, shift-right-with-insert and shift-left-with-insert controls. FSM and counter stay in the top.

## Test plan
- MULTU 7×6 → done in cycle 33; hi=0, lo=42; alu_ctrl=3'b010 throughout CALC.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2, alu_ctrl=3'b110 in CALC. DIVU 0x80000000/3 → lo=0x2AAAAAAA, hi=2.
- DIVU 5/0 → done in cycle 1; div_zero=1, hi=5, lo=0xFFFFFFFF.
- rst asserted in cycle 10 of MULTU → next cycle busy=0, hi=lo=0. A new MULTU 3×4 gives lo=12.
- During CALC:
  - start with other operands is ignored (result unchanged).
  - rd_hilo=1 → stall=1; stall falls with busy.
  - start in the DONE cycle → second done exactly 33 cycles later.
